// File: rtl/fir_delay_mc.sv
// Multi-channel time-multiplexed delay line / comb stage.
// One sample per channel is stored per ADC frame; results are emitted one channel per cycle.
module fir_delay_mc #(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned LENGTH   = 10,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned DW = $clog2(LENGTH + 1),
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         START_FLAG,
  input  logic                         MODE,
  input  logic [DW-1:0]                DELAY,
  input  logic [CHANNELS*BITSIZE-1:0]  DATA_IN,
  output logic [BITSIZE-1:0]           DATA_OUT,
  output logic [CW-1:0]                DATA_CH,
  output logic                         DATA_VALID,
  output logic                         BUSY,
  output logic                         OVERRUN
);

  localparam int unsigned PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned AW = (CHANNELS * LENGTH > 1) ? $clog2(CHANNELS * LENGTH) : 1;
  localparam logic [BITSIZE-1:0] MID    = {1'b1, {(BITSIZE-1){1'b0}}};
  localparam logic [DW-1:0]      LEN_D  = DW'(LENGTH);
  localparam logic [PW-1:0]      LAST_P = PW'(LENGTH - 1);
  localparam logic [CW-1:0]      LAST_C = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StProc, StFin} state_t;

  state_t                        state_q;
  logic                          start_q;
  logic [CW-1:0]                 ch_q;
  logic [PW-1:0]                 wp_q;
  logic [DW-1:0]                 fill_q;
  logic                          mode_q;
  logic [DW-1:0]                 delay_q;
  logic [CHANNELS*BITSIZE-1:0]   x_q;

  logic [BITSIZE-1:0] ring [CHANNELS*LENGTH];

  logic                          start;
  logic [BITSIZE-1:0]            x_cur;
  logic [BITSIZE-1:0]            d_val;
  logic [BITSIZE-1:0]            comb_sat;
  logic [BITSIZE-1:0]            result;
  logic signed [BITSIZE+1:0]     diff;
  logic [AW-1:0]                 rd_addr;
  logic [AW-1:0]                 wr_addr;
  logic                          ram_we;
  int                            rd_idx;

  always_comb begin
    start   = START_FLAG & ~start_q;
    x_cur   = x_q[int'(ch_q)*BITSIZE +: BITSIZE];
    rd_idx  = int'(wp_q) - int'(delay_q);
    if (rd_idx < 0) rd_idx = rd_idx + int'(LENGTH);
    rd_addr = AW'(int'(ch_q) * int'(LENGTH) + rd_idx);
    wr_addr = AW'(int'(ch_q) * int'(LENGTH) + int'(wp_q));
    ram_we  = (state_q == StProc) && EN;

    // Read happens before this frame's write, so D=LENGTH sees the oldest stored sample.
    if (delay_q == '0)          d_val = x_cur;
    else if (fill_q < delay_q)  d_val = MID;
    else                        d_val = ring[rd_addr];

    diff = $signed({2'b00, x_cur}) - $signed({2'b00, d_val}) + $signed({2'b00, MID});
    if (diff[BITSIZE+1])    comb_sat = '0;
    else if (diff[BITSIZE]) comb_sat = '1;
    else                    comb_sat = diff[BITSIZE-1:0];

    result = mode_q ? comb_sat : d_val;
  end

  always_ff @(posedge CLK) begin
    if (ram_we) ring[wr_addr] <= x_cur;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      ch_q       <= '0;
      wp_q       <= '0;
      fill_q     <= '0;
      mode_q     <= 1'b0;
      delay_q    <= '0;
      x_q        <= '0;
      DATA_OUT   <= MID;
      DATA_CH    <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      start_q    <= START_FLAG;
      DATA_VALID <= 1'b0;
      if (start && BUSY) OVERRUN <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start && EN) begin
            x_q     <= DATA_IN;
            mode_q  <= MODE;
            delay_q <= (DELAY > LEN_D) ? LEN_D : DELAY;
            ch_q    <= '0;
            BUSY    <= 1'b1;
            state_q <= StProc;
          end
        end
        StProc: begin
          if (!EN) begin
            BUSY    <= 1'b0;
            state_q <= StIdle;
          end else begin
            DATA_OUT   <= result;
            DATA_CH    <= ch_q;
            DATA_VALID <= 1'b1;
            if (ch_q == LAST_C) state_q <= StFin;
            else                ch_q    <= ch_q + CW'(1);
          end
        end
        StFin: begin
          wp_q    <= (wp_q == LAST_P) ? '0 : wp_q + PW'(1);
          fill_q  <= (fill_q == LEN_D) ? fill_q : fill_q + DW'(1);
          BUSY    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_delay_mc.sv
// Directed bench for fir_delay_mc: delay, comb, saturation, wrap, reset and handshake cases.
module tb_fir_delay_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        START_FLAG;
  logic        MODE;
  logic [3:0]  DELAY;
  logic [63:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic [1:0]  DATA_CH;
  logic        DATA_VALID;
  logic        BUSY;
  logic        OVERRUN;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  fir_delay_mc #(
    .BITSIZE  (16),
    .LENGTH   (10),
    .CHANNELS (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .START_FLAG (START_FLAG),
    .MODE       (MODE),
    .DELAY      (DELAY),
    .DATA_IN    (DATA_IN),
    .DATA_OUT   (DATA_OUT),
    .DATA_CH    (DATA_CH),
    .DATA_VALID (DATA_VALID),
    .BUSY       (BUSY),
    .OVERRUN    (OVERRUN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] e);
    return {e, c, b, a};
  endfunction

  function automatic logic [15:0] wav(input int n, input int k);
    return 16'(n * 32'h0ACE + k * 32'h1111 + 32'h4000);
  endfunction

  // One frame: strobe, then check each channel result at its slot.
  // drop: lower EN after ch0; restrobe: second start edge two cycles after the first.
  task automatic frame(input string tag, input logic m, input logic [3:0] d,
                       input logic [63:0] x, input logic [63:0] exp,
                       input logic drop, input logic restrobe);
    MODE = m; DELAY = d; DATA_IN = x; START_FLAG = 1'b1;
    tick();
    chk({tag, "/busy_hi"}, 32'(BUSY), 32'd1);
    START_FLAG = 1'b0; MODE = ~m; DELAY = 4'd0; DATA_IN = ~x;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (drop && k == 1) begin
        chk({tag, "/abort_valid"}, 32'(DATA_VALID), 32'd0);
        chk({tag, "/abort_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "/abort_hold"}, 32'(DATA_OUT), 32'(exp[15:0]));
        break;
      end
      chk({tag, "/valid"}, 32'(DATA_VALID), 32'd1);
      chk({tag, "/ch"}, 32'(DATA_CH), 32'(k));
      chk({tag, "/out"}, 32'(DATA_OUT), 32'(exp[k*16 +: 16]));
      if (drop && k == 0) EN = 1'b0;
      if (restrobe && k == 0) START_FLAG = 1'b1;
      if (restrobe && k == 1) begin
        START_FLAG = 1'b0;
        chk({tag, "/overrun"}, 32'(OVERRUN), 32'd1);
      end
    end
    if (!drop) begin
      tick();
      chk({tag, "/busy_lo"}, 32'(BUSY), 32'd0);
      chk({tag, "/valid_lo"}, 32'(DATA_VALID), 32'd0);
    end
    tick();
    EN = 1'b1;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; START_FLAG = 1'b0; MODE = 1'b0; DELAY = 4'd0; DATA_IN = '0;
    #2;
    chk("rst/out", 32'(DATA_OUT), 32'h8000);
    chk("rst/ch", 32'(DATA_CH), 32'd0);
    chk("rst/valid", 32'(DATA_VALID), 32'd0);
    chk("rst/busy", 32'(BUSY), 32'd0);
    chk("rst/overrun", 32'(OVERRUN), 32'd0);
    @(negedge CLK);
    RST = 1'b0; EN = 1'b1;
    tick();

    // Delay mode, D=3: primed after three frames
    for (int n = 0; n < 6; n++) begin
      frame("delay", 1'b0, 4'd3,
            pack4(16'(32'h8000 + n), 16'(32'h1000 + n), 16'(32'h2000 + n), 16'(32'h3000 + n)),
            (n < 3) ? {4{16'h8000}} :
              pack4(16'(32'h8000 + n - 3), 16'(32'h1000 + n - 3),
                    16'(32'h2000 + n - 3), 16'(32'h3000 + n - 3)),
            1'b0, 1'b0);
    end

    // Comb mode, D=2, constant input
    do_reset();
    for (int n = 0; n < 4; n++)
      frame("comb", 1'b1, 4'd2, {4{16'h9000}},
            (n < 2) ? {4{16'h9000}} : {4{16'h8000}}, 1'b0, 1'b0);

    // Comb saturation, D=1, full-scale alternation: output clamps to the input value
    do_reset();
    for (int n = 0; n < 4; n++) begin
      logic [15:0] a;
      a = (n % 2 == 0) ? 16'hFFFF : 16'h0000;
      frame("sat", 1'b1, 4'd1, pack4(a, ~a, a, ~a), pack4(a, ~a, a, ~a), 1'b0, 1'b0);
    end

    // Full-depth delay with clamped DELAY and pointer wrap
    do_reset();
    for (int n = 0; n < 25; n++)
      frame("wrap", 1'b0, 4'd15, pack4(wav(n, 0), wav(n, 1), wav(n, 2), wav(n, 3)),
            (n < 10) ? {4{16'h8000}} :
              pack4(wav(n - 10, 0), wav(n - 10, 1), wav(n - 10, 2), wav(n - 10, 3)),
            1'b0, 1'b0);

    // Asynchronous reset mid-frame, then fill restarts from zero
    MODE = 1'b0; DELAY = 4'd1; DATA_IN = {4{16'h7777}}; START_FLAG = 1'b1;
    tick();
    START_FLAG = 1'b0;
    tick();
    tick();
    #1 RST = 1'b1;
    #1;
    chk("arst/busy", 32'(BUSY), 32'd0);
    chk("arst/valid", 32'(DATA_VALID), 32'd0);
    chk("arst/out", 32'(DATA_OUT), 32'h8000);
    chk("arst/ch", 32'(DATA_CH), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    frame("post_rst", 1'b0, 4'd3, {4{16'h5555}}, {4{16'h8000}}, 1'b0, 1'b0);

    // Start edge while busy: ignored, OVERRUN sticky until reset
    do_reset();
    frame("ovr", 1'b0, 4'd0, pack4(16'h0101, 16'h0202, 16'h0303, 16'h0404),
          pack4(16'h0101, 16'h0202, 16'h0303, 16'h0404), 1'b0, 1'b1);
    chk("ovr/sticky1", 32'(OVERRUN), 32'd1);
    frame("ovr2", 1'b0, 4'd0, {4{16'hABCD}}, {4{16'hABCD}}, 1'b0, 1'b0);
    chk("ovr/sticky2", 32'(OVERRUN), 32'd1);
    do_reset();
    chk("ovr/cleared", 32'(OVERRUN), 32'd0);

    // EN drop during PROC: abort keeps wp/fill, ch0 already written
    frame("abA", 1'b0, 4'd1, {4{16'h1111}}, {4{16'h8000}}, 1'b0, 1'b0);
    frame("abB", 1'b0, 4'd1, {4{16'h2222}}, {4{16'h1111}}, 1'b1, 1'b0);
    tick();
    chk("abort/idle_valid", 32'(DATA_VALID), 32'd0);
    frame("abC", 1'b0, 4'd1, {4{16'h3333}}, {4{16'h1111}}, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
